// File: rtl/vending_machine_multi.sv
// Multi-drink vending controller: coin credit, per-drink stock,
// greedy change return paced by a tick counter.
module vending_machine_multi #(
  parameter int N_DRINK = 4,
  parameter int N_COIN = 3,
  parameter int CW = 7,
  parameter logic [N_DRINK*CW-1:0] PRICE_LIST =
    {7'd30, 7'd25, 7'd20, 7'd55},
  parameter logic [N_COIN*CW-1:0] COIN_LIST =
    {7'd50, 7'd10, 7'd5},
  parameter int MAX_CREDIT = 80,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 9,
  parameter int CHANGE_TICKS = 100000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_COIN-1:0]          coin,
  input  logic [N_DRINK-1:0]         pick,
  input  logic                       cancel,
  input  logic                       restock,
  output logic [CW-1:0]              credit,
  output logic [N_DRINK-1:0]         avail,
  output logic [N_DRINK-1:0]         sold_out,
  output logic                       vend_valid,
  output logic [$clog2(N_DRINK)-1:0] vend_id,
  output logic                       change_valid,
  output logic [N_COIN-1:0]          change_coin,
  output logic                       busy
);

  localparam int IDW = $clog2(N_DRINK);
  localparam int TW = $clog2(CHANGE_TICKS + 1);
  localparam int SW = CW + 2;

  typedef enum logic {
    S_INSERT,
    S_CHANGE
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_credit;
  logic [STOCK_W-1:0] r_stock [N_DRINK];
  logic [TW-1:0]      r_cnt;
  logic               r_vend_valid;
  logic [IDW-1:0]     r_vend_id;
  logic               r_change_valid;
  logic [N_COIN-1:0]  r_change_coin;

  logic [SW-1:0]      w_coin_sum;
  logic [N_DRINK-1:0] w_buyable;
  logic               w_win;
  logic [IDW-1:0]     w_win_id;
  logic [CW-1:0]      w_win_price;
  logic [SW-1:0]      w_base;
  logic [SW-1:0]      w_raw;
  logic [CW-1:0]      w_ins_credit;
  logic               w_chg_ok;
  logic [N_COIN-1:0]  w_chg_hot;
  logic [CW-1:0]      w_chg_val;
  logic [TW-1:0]      w_cnt_nxt;
  logic               w_fire;

  // Total value of all coins arriving this cycle.
  always_comb begin
    w_coin_sum = '0;
    for (int j = 0; j < N_COIN; j++) begin
      if (coin[j]) begin
        w_coin_sum = w_coin_sum + SW'(COIN_LIST[j*CW +: CW]);
      end
    end
  end

  // Which drinks could be bought with the current credit and stock.
  always_comb begin
    for (int i = 0; i < N_DRINK; i++) begin
      w_buyable[i] = (r_credit >= PRICE_LIST[i*CW +: CW]) &&
                     (r_stock[i] != '0);
    end
  end

  // Lowest-index purchasable pick wins; descending scan keeps it last.
  always_comb begin
    w_win = 1'b0;
    w_win_id = '0;
    for (int i = N_DRINK - 1; i >= 0; i--) begin
      if (pick[i] && w_buyable[i]) begin
        w_win = 1'b1;
        w_win_id = IDW'(i);
      end
    end
  end

  assign w_win_price = PRICE_LIST[w_win_id*CW +: CW];
  assign w_base = w_win ? (SW'(r_credit) - SW'(w_win_price))
                        : SW'(r_credit);
  assign w_raw = w_base + w_coin_sum;
  assign w_ins_credit = (w_raw > SW'(MAX_CREDIT)) ? CW'(MAX_CREDIT)
                                                  : w_raw[CW-1:0];

  // Largest denomination that still fits in the remaining credit.
  always_comb begin
    w_chg_ok = 1'b0;
    w_chg_hot = '0;
    w_chg_val = '0;
    for (int j = 0; j < N_COIN; j++) begin
      if (COIN_LIST[j*CW +: CW] <= r_credit) begin
        w_chg_ok = 1'b1;
        w_chg_hot = '0;
        w_chg_hot[j] = 1'b1;
        w_chg_val = COIN_LIST[j*CW +: CW];
      end
    end
  end

  assign w_cnt_nxt = r_cnt + TW'(1);
  assign w_fire = (w_cnt_nxt == TW'(CHANGE_TICKS));

  // Main FSM: credit, stock, change pacing and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INSERT;
      r_credit <= '0;
      r_cnt <= '0;
      r_vend_valid <= 1'b0;
      r_vend_id <= '0;
      r_change_valid <= 1'b0;
      r_change_coin <= '0;
      for (int i = 0; i < N_DRINK; i++) begin
        r_stock[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      r_vend_valid <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin <= '0;
      case (r_state)
        S_INSERT: begin
          r_cnt <= '0;
          r_credit <= w_ins_credit;
          if (w_win) begin
            r_stock[w_win_id] <= r_stock[w_win_id] - STOCK_W'(1);
            r_vend_valid <= 1'b1;
            r_vend_id <= w_win_id;
            r_state <= S_CHANGE;
          end else if (cancel) begin
            r_state <= S_CHANGE;
          end
        end
        S_CHANGE: begin
          if (r_credit == '0) begin
            r_cnt <= '0;
            r_state <= S_INSERT;
          end else if (w_fire) begin
            r_cnt <= '0;
            if (w_chg_ok) begin
              r_credit <= r_credit - w_chg_val;
              r_change_valid <= 1'b1;
              r_change_coin <= w_chg_hot;
            end else begin
              r_credit <= '0;
              r_state <= S_INSERT;
            end
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= S_INSERT;
      endcase
      // Restock overrides any same-cycle decrement.
      if (restock) begin
        for (int i = 0; i < N_DRINK; i++) begin
          r_stock[i] <= STOCK_W'(STOCK_INIT);
        end
      end
    end
  end

  // Per-drink availability and empty flags.
  always_comb begin
    for (int i = 0; i < N_DRINK; i++) begin
      avail[i] = (r_state == S_INSERT) && w_buyable[i];
      sold_out[i] = (r_stock[i] == '0);
    end
  end

  assign credit = r_credit;
  assign busy = (r_state == S_CHANGE);
  assign vend_valid = r_vend_valid;
  assign vend_id = r_vend_id;
  assign change_valid = r_change_valid;
  assign change_coin = r_change_coin;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus
// random traffic against a coin-queue reference model.
module tb_vending_machine_multi;

  localparam int TICKS = 4;
  localparam int SINIT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] coin;
  logic [3:0] pick;
  logic       cancel;
  logic       restock;
  logic [6:0] credit;
  logic [3:0] avail;
  logic [3:0] sold_out;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       change_valid;
  logic [2:0] change_coin;
  logic       busy;

  vending_machine_multi #(
    .CHANGE_TICKS(TICKS),
    .STOCK_INIT(SINIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin(coin),
    .pick(pick),
    .cancel(cancel),
    .restock(restock),
    .credit(credit),
    .avail(avail),
    .sold_out(sold_out),
    .vend_valid(vend_valid),
    .vend_id(vend_id),
    .change_valid(change_valid),
    .change_coin(change_coin),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int price [4] = '{55, 20, 25, 30};
  int coinv [3] = '{5, 10, 50};

  int m_credit;
  int m_stock [4];
  bit m_chg;
  int m_el;
  int m_q [$];
  bit m_vv;
  int m_vid;
  bit m_cv;
  int m_cc;

  task automatic m_reset();
    m_credit = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = SINIT;
    m_chg = 0;
    m_el = 0;
    m_q.delete();
    m_vv = 0;
    m_cv = 0;
  endtask

  // Plan the whole greedy refund up front as a list of coins.
  task automatic m_enter();
    int r;
    int k;
    m_chg = 1;
    m_el = 0;
    m_q.delete();
    r = m_credit;
    while (r >= coinv[0]) begin
      k = 0;
      for (int j = 0; j < 3; j++) if (coinv[j] <= r) k = j;
      m_q.push_back(k);
      r -= coinv[k];
    end
  endtask

  task automatic m_step(input logic [2:0] c, input logic [3:0] p,
                        input logic can, input logic rs);
    int sum;
    int win;
    m_vv = 0;
    m_cv = 0;
    if (!m_chg) begin
      sum = 0;
      for (int j = 0; j < 3; j++) if (c[j]) sum += coinv[j];
      win = -1;
      for (int i = 3; i >= 0; i--)
        if (p[i] && m_credit >= price[i] && m_stock[i] > 0) win = i;
      if (win >= 0) begin
        m_credit = m_credit - price[win] + sum;
        if (m_credit > 80) m_credit = 80;
        m_stock[win]--;
        m_vv = 1;
        m_vid = win;
        m_enter();
      end else begin
        m_credit = m_credit + sum;
        if (m_credit > 80) m_credit = 80;
        if (can) m_enter();
      end
    end else begin
      m_el++;
      if (m_credit == 0) begin
        m_chg = 0;
      end else if (m_el % TICKS == 0) begin
        if (m_q.size() > 0) begin
          m_cc = m_q.pop_front();
          m_credit -= coinv[m_cc];
          m_cv = 1;
        end else begin
          m_credit = 0;
          m_chg = 0;
        end
      end
    end
    if (rs) for (int i = 0; i < 4; i++) m_stock[i] = SINIT;
  endtask

  task automatic compare_all();
    logic [3:0] ea;
    logic [3:0] es;
    for (int i = 0; i < 4; i++) begin
      ea[i] = !m_chg && m_credit >= price[i] && m_stock[i] > 0;
      es[i] = (m_stock[i] == 0);
    end
    chk("credit", credit, m_credit);
    chk("busy", busy, m_chg);
    chk("vend_valid", vend_valid, m_vv);
    if (m_vv) chk("vend_id", vend_id, m_vid);
    chk("change_valid", change_valid, m_cv);
    if (m_cv) chk("change_coin", change_coin, 1 << m_cc);
    chk("avail", avail, ea);
    chk("sold_out", sold_out, es);
  endtask

  task automatic cycle(input logic [2:0] c, input logic [3:0] p,
                       input logic can, input logic rs);
    @(negedge clk);
    coin = c;
    pick = p;
    cancel = can;
    restock = rs;
    m_step(c, p, can, rs);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_done();
    int n;
    n = 0;
    while (m_chg && n < 200) begin
      cycle(3'b000, 4'b0000, 1'b0, 1'b0);
      n++;
    end
    if (m_chg) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    coin = '0;
    pick = '0;
    cancel = 1'b0;
    restock = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vend_valid", vend_valid, 0);
    chk("rst_vend_id", vend_id, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_change_coin", change_coin, 0);
    chk("rst_sold_out", sold_out, 0);
    chk("rst_avail", avail, 0);
    @(negedge clk);
    rst = 1'b1;

    // 50 + 10, buy drink 0, 5 comes back
    cycle(3'b100, 4'b0000, 1'b0, 1'b0);
    cycle(3'b010, 4'b0000, 1'b0, 1'b0);
    chk("tp_credit60", credit, 60);
    cycle(3'b000, 4'b0001, 1'b0, 1'b0);
    chk("tp_vend0", vend_valid, 1);
    chk("tp_vend0_id", vend_id, 0);
    chk("tp_credit5", credit, 5);
    idle_done();

    // saturation then cancel
    cycle(3'b100, 4'b0000, 1'b0, 1'b0);
    cycle(3'b100, 4'b0000, 1'b0, 1'b0);
    chk("tp_sat80", credit, 80);
    chk("tp_avail_all", avail, 4'b1111);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0);
    idle_done();
    chk("tp_cancel_done", credit, 0);

    // multi-pick priority, then pick with same-cycle coin
    cycle(3'b100, 4'b0000, 1'b0, 1'b0);
    cycle(3'b010, 4'b0000, 1'b0, 1'b0);
    cycle(3'b000, 4'b0011, 1'b0, 1'b0);
    chk("tp_multi_id", vend_id, 0);
    chk("tp_multi_credit", credit, 5);
    idle_done();
    repeat (3) cycle(3'b010, 4'b0000, 1'b0, 1'b0);
    cycle(3'b010, 4'b1000, 1'b0, 1'b0);
    chk("tp_collide_id", vend_id, 3);
    chk("tp_collide_credit", credit, 10);
    idle_done();

    // sell out drink 1, then restock
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    repeat (2) begin
      cycle(3'b100, 4'b0000, 1'b0, 1'b0);
      cycle(3'b000, 4'b0010, 1'b0, 1'b0);
      idle_done();
    end
    chk("tp_sold1", sold_out[1], 1);
    cycle(3'b100, 4'b0000, 1'b0, 1'b0);
    chk("tp_avail1_off", avail[1], 0);
    cycle(3'b000, 4'b0010, 1'b0, 1'b0);
    chk("tp_no_vend", vend_valid, 0);
    chk("tp_credit_kept", credit, 50);
    cycle(3'b000, 4'b0000, 1'b0, 1'b1);
    chk("tp_restock", sold_out[1], 0);
    chk("tp_avail1_on", avail[1], 1);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0);
    idle_done();

    // 65 refund aborted by reset after the first coin
    cycle(3'b100, 4'b0000, 1'b0, 1'b0);
    cycle(3'b010, 4'b0000, 1'b0, 1'b0);
    cycle(3'b001, 4'b0000, 1'b0, 1'b0);
    chk("tp_credit65", credit, 65);
    cycle(3'b000, 4'b0000, 1'b1, 1'b0);
    n = 0;
    while (!m_cv && n < 50) begin
      cycle(3'b010, 4'b0000, 1'b0, 1'b0);
      n++;
    end
    if (!m_cv) chk("wait_coin", 0, 1);
    chk("tp_first50", change_coin, 3'b100);
    coin = '0;
    pick = '0;
    cancel = 1'b0;
    restock = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("tp_abort_credit", credit, 0);
    chk("tp_abort_busy", busy, 0);
    chk("tp_abort_cv", change_valid, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      cycle(($urandom % 4 == 0) ? 3'($urandom % 8) : 3'b000,
            ($urandom % 3 == 0) ? 4'($urandom % 16) : 4'b0000,
            ($urandom % 20 == 0),
            ($urandom % 40 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
